cmp_sort_ctrl: RTL and testbench

- Buffers DEPTH unsigned WIDTH-bit samples from an upstream valid/ready stream.
- Sorts them in place by bubble sort. All comparisons go through one shared WIDTH-bit magnitude comparator (less/equal/greater), one comparison per cycle.
- Streams the sorted samples out on a valid/ready interface.
- Sits between a sample source (switches/keys or a capture block) and a display or downstream consumer. It is the scheduler that sequences the comparator datapath.

---
 rtl/cmp_sort_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cmp_sort_ctrl.sv
// Batch bubble sorter: loads DEPTH samples, sorts them with one shared magnitude comparator, then streams them out.
// Define CMP_SORT_DESCEND_EN for non-increasing output order; the default build sorts non-decreasing.

module MagComparator #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             less_o,
  output logic             equal_o,
  output logic             greater_o
);

  assign less_o    = (a_i < b_i);
  assign equal_o   = (a_i == b_i);
  assign greater_o = ~less_o & ~equal_o;

endmodule

module cmp_sort_ctrl #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IW-1:0]    wrIdx_q, wrIdx_d;
  logic [IW-1:0]    rdIdx_q, rdIdx_d;
  logic [IW-1:0]    cmpIdx_q, cmpIdx_d;
  logic [IW-1:0]    passCnt_q, passCnt_d;
  logic             swapFlag_q, swapFlag_d;

  logic [IW-1:0]    cmpIdxNext;
  logic [WIDTH-1:0] cmpA, cmpB;
  logic             cmpLess, cmpEqual, cmpGreater;
  logic             doSwap;
  logic             passSwapped;

  assign cmpIdxNext = cmpIdx_q + IW'(1);
  assign cmpA       = mem_q[cmpIdx_q];
  assign cmpB       = mem_q[cmpIdxNext];

  MagComparator #(.WIDTH(WIDTH)) uCmp (
    .a_i       (cmpA),
    .b_i       (cmpB),
    .less_o    (cmpLess),
    .equal_o   (cmpEqual),
    .greater_o (cmpGreater)
  );

  // Equal pairs never swap, which keeps the sort stable in either order.
`ifdef CMP_SORT_DESCEND_EN
  assign doSwap = cmpLess & ~(cmpGreater | cmpEqual);
`else
  assign doSwap = cmpGreater & ~(cmpLess | cmpEqual);
`endif

  assign passSwapped = swapFlag_q | doSwap;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= LOAD;
      wrIdx_q    <= '0;
      rdIdx_q    <= '0;
      cmpIdx_q   <= '0;
      passCnt_q  <= '0;
      swapFlag_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      wrIdx_q    <= wrIdx_d;
      rdIdx_q    <= rdIdx_d;
      cmpIdx_q   <= cmpIdx_d;
      passCnt_q  <= passCnt_d;
      swapFlag_q <= swapFlag_d;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wrIdx_d    = wrIdx_q;
    rdIdx_d    = rdIdx_q;
    cmpIdx_d   = cmpIdx_q;
    passCnt_d  = passCnt_q;
    swapFlag_d = swapFlag_q;

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_d[wrIdx_q] = in_data;
          if (wrIdx_q == IW'(DEPTH - 1)) begin
            wrIdx_d = '0;
            state_d = SORT;
          end else begin
            wrIdx_d = wrIdx_q + IW'(1);
          end
        end
      end

      SORT: begin
        if (doSwap) begin
          mem_d[cmpIdx_q]   = cmpB;
          mem_d[cmpIdxNext] = cmpA;
        end
        // A pass ends on the last adjacent pair; stop early once a pass is swap-free.
        if (cmpIdx_q == IW'(DEPTH - 2)) begin
          cmpIdx_d   = '0;
          swapFlag_d = 1'b0;
          if (!passSwapped || passCnt_q == IW'(DEPTH - 2)) begin
            passCnt_d = '0;
            state_d   = DRAIN;
          end else begin
            passCnt_d = passCnt_q + IW'(1);
          end
        end else begin
          cmpIdx_d   = cmpIdxNext;
          swapFlag_d = passSwapped;
        end
      end

      DRAIN: begin
        if (out_ready) begin
          if (rdIdx_q == IW'(DEPTH - 1)) begin
            rdIdx_d = '0;
            state_d = LOAD;
          end else begin
            rdIdx_d = rdIdx_q + IW'(1);
          end
        end
      end

      default: state_d = LOAD;
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q == SORT);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = (state_q == DRAIN) ? mem_q[rdIdx_q] : '0;
  assign out_last  = (state_q == DRAIN) && (rdIdx_q == IW'(DEPTH - 1));

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed bench for cmp_sort_ctrl: sorted results are predicted by a counting model into a queue and checked as they drain.
// Honours CMP_SORT_DESCEND_EN to predict the reversed order and busy durations.

module tb_cmp_sort_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int expQ[$];
  int busyCycles;

  cmp_sort_ctrl #(.WIDTH(2), .DEPTH(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Loads four samples and predicts the sorted order by counting occurrences of each value.
  task automatic applyStimulus(input int s0, input int s1, input int s2, input int s3);
    int s[4];
    int w;
    s = '{s0, s1, s2, s3};
`ifdef CMP_SORT_DESCEND_EN
    for (int v = 3; v >= 0; v--)
      for (int k = 0; k < 4; k++) if (s[k] == v) expQ.push_back(v);
`else
    for (int v = 0; v < 4; v++)
      for (int k = 0; k < 4; k++) if (s[k] == v) expQ.push_back(v);
`endif
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = s[k][1:0];
      w = 0;
      while (!in_ready && w < 100) begin
        @(posedge sys_clk); #1;
        w++;
      end
      @(posedge sys_clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic drainBatch(input bit stall);
    int cyc = 0;
    int pat = 0;
    int xfers = 0;
    while (expQ.size() > 0 && cyc < 300) begin
      if (out_valid) begin
        out_ready = stall ? ((pat % 4 == 0) || (pat % 4 == 3)) : 1'b1;
        pat++;
        checkOutput("out_data", out_data, expQ[0]);
        checkOutput("out_last", out_last, (expQ.size() == 1) ? 1 : 0);
        checkOutput("in_ready_drain", in_ready, 0);
        if (out_ready) begin
          void'(expQ.pop_front());
          xfers++;
        end
      end
      @(posedge sys_clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    checkOutput("xfer_count", xfers, 4);
    checkOutput("in_ready_after", in_ready, 1);
    checkOutput("out_valid_after", out_valid, 0);
  endtask

  initial begin
    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    in_data   = 2'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_busy", busy, 0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    applyStimulus(3, 1, 2, 0);
    countBusy(busyCycles);
    checkOutput("valid_after_sort", out_valid, 1);
    drainBatch(1'b0);

    applyStimulus(0, 1, 2, 3);
    countBusy(busyCycles);
`ifdef CMP_SORT_DESCEND_EN
    checkOutput("busy_ascending_in", busyCycles, 9);
`else
    checkOutput("busy_ascending_in", busyCycles, 3);
`endif
    drainBatch(1'b0);

    applyStimulus(3, 2, 1, 0);
    countBusy(busyCycles);
`ifdef CMP_SORT_DESCEND_EN
    checkOutput("busy_descending_in", busyCycles, 3);
`else
    checkOutput("busy_descending_in", busyCycles, 9);
`endif
    drainBatch(1'b0);

    applyStimulus(2, 2, 0, 2);
    countBusy(busyCycles);
    drainBatch(1'b1);

    // Abort a batch in its second sort cycle; nothing from it may appear.
    applyStimulus(3, 2, 1, 0);
    @(posedge sys_clk); #1;
    checkOutput("busy_before_abort", busy, 1);
    sys_rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_out_data", out_data, 0);
    checkOutput("abort_out_last", out_last, 0);
    checkOutput("abort_busy", busy, 0);
    expQ.delete();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    applyStimulus(1, 0, 1, 0);
    countBusy(busyCycles);
    drainBatch(1'b0);

    applyStimulus(1, 3, 0, 2);
    countBusy(busyCycles);
    drainBatch(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
